// File: rtl/ibex_pkg.sv
// Shared types for the execute-stage multi-cycle sequencer: operation classes and FSM states.
package ibex_pkg;

   typedef enum logic [1:0] {
      ExSingle = 2'd0,
      ExMul    = 2'd1,
      ExDiv    = 2'd2,
      ExPmul   = 2'd3
   } ex_op_class_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } ex_ctrl_state_e;

endpackage

// File: rtl/ibex_ex_multicycle_ctrl.sv
// Execute-stage sequencer for multi-cycle ops (mul, div, packed-SIMD mul).
// Optional stall-cycle counter enabled by defining IBEX_EX_CTRL_PERF_EN.
module ibex_ex_multicycle_ctrl
   import ibex_pkg::*;
#(
   parameter int unsigned MulCycles  = 3,
   parameter int unsigned DivCycles  = 37,
   parameter int unsigned PextCycles = 2,
   localparam int unsigned Cw        = $clog2(DivCycles + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          start_i,
   input  logic [1:0]    op_class_i,
   input  logic          kill_i,
   input  logic          ready_id_i,
   input  logic          early_done_i,
   input  logic          data_ind_timing_i,
   output logic          busy_o,
   output logic          first_cycle_o,
   output logic [1:0]    imd_val_we_o,
   output logic [Cw-1:0] step_o,
   output logic          ex_valid_o,
   output logic [31:0]   perf_stall_cnt_o
);

   ex_ctrl_state_e state_q, state_d;
   ex_op_class_e   class_q, class_d, class_in;
   logic [Cw-1:0]  cnt_q, cnt_d;
   logic           finish;

   assign class_in = ex_op_class_e'(op_class_i);

   // Counter preload: the start cycle and the final RUN cycle are not counted.
   function automatic logic [Cw-1:0] load_val(ex_op_class_e c);
      logic [Cw-1:0] v;
      unique case (c)
         ExMul:   v = Cw'(MulCycles - 2);
         ExDiv:   v = Cw'(DivCycles - 2);
         ExPmul:  v = Cw'(PextCycles - 2);
         default: v = '0;
      endcase
      return v;
   endfunction

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         class_q <= ExSingle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         class_q <= class_d;
         cnt_q   <= cnt_d;
      end
   end

   assign finish = (cnt_q == '0) ||
                   ((class_q == ExDiv) && early_done_i && !data_ind_timing_i);

   always_comb begin
      state_d       = state_q;
      class_d       = class_q;
      cnt_d         = cnt_q;
      first_cycle_o = 1'b0;
      imd_val_we_o  = 2'b00;
      ex_valid_o    = 1'b0;
      if (kill_i) begin
         state_d = StIdle;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  first_cycle_o = 1'b1;
                  if (class_in == ExSingle) begin
                     ex_valid_o = 1'b1;
                  end else begin
                     imd_val_we_o = 2'b11;
                     cnt_d        = load_val(class_in);
                     class_d      = class_in;
                     state_d      = StRun;
                  end
               end
            end
            StRun: begin
               if (finish) begin
                  ex_valid_o = 1'b1;
                  cnt_d      = '0;
                  state_d    = ready_id_i ? StIdle : StDone;
               end else begin
                  imd_val_we_o = 2'b11;
                  cnt_d        = cnt_q - 1'b1;
               end
            end
            StDone: begin
               ex_valid_o = 1'b1;
               if (ready_id_i) state_d = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign busy_o = (state_q != StIdle);
   assign step_o = (state_q == StRun) ? cnt_q : '0;

`ifdef IBEX_EX_CTRL_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_q <= '0;
      end else if ((state_q != StIdle) && (perf_q != 32'hFFFF_FFFF)) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_stall_cnt_o = perf_q;
`else
   assign perf_stall_cnt_o = 32'h0;
`endif

   // ID must never issue while an op is in flight.
   start_while_busy_a: assert property (@(posedge clk_i) disable iff (rst_i)
                                        !(start_i && busy_o));

endmodule

// File: tb/tb_ibex_ex_multicycle_ctrl.sv
// Self-checking bench for ibex_ex_multicycle_ctrl: vector table plus hand-written corner cases.
module tb_ibex_ex_multicycle_ctrl;
   import ibex_pkg::*;

   localparam int unsigned MulC  = 3;
   localparam int unsigned DivC  = 37;
   localparam int unsigned PextC = 2;
   localparam int unsigned Cw    = $clog2(DivC + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start, kill, ready, early, dit;
   logic [1:0]    op_class;
   logic          busy, first, valid;
   logic [1:0]    we;
   logic [Cw-1:0] step;
   logic [31:0]   perf;

   always #5 clk = ~clk;

   ibex_ex_multicycle_ctrl #(
      .MulCycles (MulC),
      .DivCycles (DivC),
      .PextCycles(PextC)
   ) u_dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .start_i          (start),
      .op_class_i       (op_class),
      .kill_i           (kill),
      .ready_id_i       (ready),
      .early_done_i     (early),
      .data_ind_timing_i(dit),
      .busy_o           (busy),
      .first_cycle_o    (first),
      .imd_val_we_o     (we),
      .step_o           (step),
      .ex_valid_o       (valid),
      .perf_stall_cnt_o (perf)
   );

   typedef struct {
      ex_op_class_e cls;
      int           early_at;  // cycle index of early_done pulse, -1 for none
      bit           dit;
      int           stall;     // cycles ID withholds ready after valid rises
      int           lat;       // expected cycle index of first ex_valid
   } vec_t;

   int checks = 0;
   int errors = 0;
   int exp_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int ncyc(ex_op_class_e c);
      case (c)
         ExMul:   return MulC;
         ExDiv:   return DivC;
         ExPmul:  return PextC;
         default: return 1;
      endcase
   endfunction

   task automatic run_vec(input vec_t v, input string tag);
      int  held;
      bit  seen;
      bit  multi;
      int  n;
      int  e;
      held  = 0;
      seen  = 0;
      multi = (v.cls != ExSingle);
      n     = ncyc(v.cls);
      exp_q.push_back(v.lat);
      for (int c = 0; c <= v.lat + v.stall + 1; c++) begin
         @(negedge clk);
         start    = (c == 0);
         op_class = v.cls;
         early    = (c == v.early_at);
         dit      = v.dit;
         kill     = 1'b0;
         ready    = 1'b0;
         #1;
         if (valid && !seen) begin
            seen = 1;
            if (exp_q.size() == 0) begin
               chk({tag, " unexpected_valid"}, 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk({tag, " latency"}, c, e);
            end
         end
         if (valid) begin
            ready = (held >= v.stall);
            held++;
         end
         chk({tag, " valid"}, valid, (c >= v.lat && c <= v.lat + v.stall));
         chk({tag, " busy"}, busy, (multi && c >= 1 && c <= v.lat + v.stall));
         chk({tag, " first"}, first, (c == 0));
         chk({tag, " we"}, we, (multi && c < v.lat) ? 3 : 0);
         chk({tag, " step"}, step, (multi && c >= 1 && c <= v.lat) ? n - 1 - c : 0);
      end
      if (!seen) begin
         chk({tag, " valid_never_seen"}, 0, 1);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
   endtask

   vec_t vecs[10];
   int   p0;
   bit   got_valid;

   initial begin
      vecs[0] = '{ExSingle, -1, 1'b0, 0, 0};
      vecs[1] = '{ExMul,    -1, 1'b0, 0, 2};
      vecs[2] = '{ExPmul,   -1, 1'b0, 0, 1};
      vecs[3] = '{ExDiv,    -1, 1'b0, 0, 36};
      vecs[4] = '{ExDiv,     5, 1'b0, 0, 5};
      vecs[5] = '{ExDiv,     5, 1'b1, 0, 36};
      vecs[6] = '{ExMul,     1, 1'b0, 0, 2};
      vecs[7] = '{ExPmul,   -1, 1'b0, 4, 1};
      vecs[8] = '{ExDiv,     1, 1'b0, 0, 1};
      vecs[9] = '{ExMul,    -1, 1'b0, 2, 2};

      rst = 1'b1; start = 0; kill = 0; ready = 0; early = 0; dit = 0; op_class = 2'd0;
      #1;
      chk("reset busy", busy, 0);
      chk("reset valid", valid, 0);
      chk("reset we", we, 0);
      chk("reset step", step, 0);
      chk("reset first", first, 0);
      chk("reset perf", perf, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Kill a DIV at cycle 10: no result, idle next cycle.
      got_valid = 0;
      for (int c = 0; c <= 11; c++) begin
         @(negedge clk);
         start    = (c == 0);
         op_class = ExDiv;
         dit      = 1'b1;
         early    = 1'b0;
         ready    = 1'b1;
         kill     = (c == 10);
         #1;
         if (valid) got_valid = 1;
         if (c == 10) begin
            chk("kill busy_in_kill_cycle", busy, 1);
            chk("kill we", we, 0);
            chk("kill step", step, DivC - 1 - 10);
         end
         if (c == 11) begin
            chk("kill busy_after", busy, 0);
            chk("kill step_after", step, 0);
         end
      end
      chk("kill no_valid", got_valid, 0);
      run_vec(vecs[1], "mul_after_kill");

      // Start coincident with kill is dropped.
      @(negedge clk);
      start = 1'b1; op_class = ExSingle; kill = 1'b1; ready = 1'b1; early = 0;
      #1;
      chk("kill_start single valid", valid, 0);
      chk("kill_start single first", first, 0);
      @(negedge clk);
      op_class = ExMul;
      #1;
      chk("kill_start mul we", we, 0);
      @(negedge clk);
      start = 1'b0; kill = 1'b0;
      #1;
      chk("kill_start mul busy", busy, 0);

      // Stall counter: MUL with a 2-cycle ID stall spends 4 cycles in RUN/DONE.
      p0 = perf;
      run_vec(vecs[9], "perf_mul");
`ifdef IBEX_EX_CTRL_PERF_EN
      chk("perf delta", perf - p0, 4);
`else
      chk("perf tied_zero", perf, 0);
`endif

      // Async reset mid-RUN.
      @(negedge clk);
      start = 1'b1; op_class = ExDiv; dit = 1'b1; ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1;
      chk("midrun busy_before_rst", busy, 1);
      rst = 1'b1;
      #1;
      chk("rst busy", busy, 0);
      chk("rst valid", valid, 0);
      chk("rst we", we, 0);
      chk("rst step", step, 0);
      chk("rst perf", perf, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("post_rst valid", valid, 0);
         chk("post_rst busy", busy, 0);
      end
      run_vec(vecs[0], "single_after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
